// File: rtl/oddr_seq_pkg.sv
// Shared types and sizing helpers for the ODDR word sequencer.
package oddr_seq_pkg;

  typedef enum logic [1:0] {
    HOLD  = 2'd0,
    IDLE  = 2'd1,
    SHIFT = 2'd2
  } state_t;

  // Bits needed to hold a counter value 0..max_val (never less than 1).
  function automatic int ctr_width(input int max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/oddr_lock_sync.sv
// Two-flop PLL lock synchronizer plus settle counter; lock_stable is high only
// once the synced lock has been high for SETTLE_CYCLES consecutive cycles.
module oddr_lock_sync
  import oddr_seq_pkg::*;
#(
  parameter int SETTLE_CYCLES = 64
) (
  input  logic clk,
  input  logic rst_n,
  input  logic pll_locked,
  output logic lock_stable
);

  localparam int CNT_W = ctr_width(SETTLE_CYCLES);
  localparam logic [CNT_W-1:0] SETTLE_MAX = CNT_W'(SETTLE_CYCLES);

  logic             sync1;
  logic             sync2;
  logic [CNT_W-1:0] settle_cnt;

  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1      <= 1'b0;
      sync2      <= 1'b0;
      settle_cnt <= '0;
    end else begin
      sync1 <= pll_locked;
      sync2 <= sync1;
      if (!sync2) begin
        settle_cnt <= '0;
      end else if (settle_cnt != SETTLE_MAX) begin
        settle_cnt <= settle_cnt + 1'b1;
      end
    end
  end

  // Gated by sync2 so a lock drop is seen the same cycle, not one later.
  assign lock_stable = sync2 && (settle_cnt == SETTLE_MAX);

endmodule

// File: rtl/oddr_word_sequencer.sv
// Feeds an ODDR two bits per clk (LSB first) from valid/ready words and holds it
// in reset until the PLL lock has settled. Define ODDR_SEQ_TRAINING_EN for a
// 1/0 training pattern on the data outputs while idle.
module oddr_word_sequencer
  import oddr_seq_pkg::*;
#(
  parameter int   WORD_W        = 8,
  parameter int   SETTLE_CYCLES = 64,
  parameter logic IDLE_LEVEL    = 1'b0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              pll_locked,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [WORD_W-1:0] s_data,
  output logic              oddr_d1,
  output logic              oddr_d2,
  output logic              oddr_ce,
  output logic              oddr_rst,
  output logic              busy,
  output logic              underrun
);

  localparam int BEATS  = WORD_W / 2;
  localparam int BEAT_W = ctr_width(BEATS - 1);
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);

`ifdef ODDR_SEQ_TRAINING_EN
  localparam logic IDLE_D1 = 1'b1;
  localparam logic IDLE_D2 = 1'b0;
`else
  localparam logic IDLE_D1 = IDLE_LEVEL;
  localparam logic IDLE_D2 = IDLE_LEVEL;
`endif

  logic lock_stable;

  oddr_lock_sync #(
    .SETTLE_CYCLES(SETTLE_CYCLES)
  ) u_lock_sync (
    .clk        (clk),
    .rst_n      (rst_n),
    .pll_locked (pll_locked),
    .lock_stable(lock_stable)
  );

  state_t              state, state_next;
  logic [WORD_W-1:0]   sreg, sreg_next;
  logic [BEAT_W-1:0]   beat, beat_next;
  logic                d1_next, d2_next, ce_next, rst_next;
  logic                ready_next, busy_next, underrun_next;
  logic                accept, load, shift;

  assign accept = s_valid & s_ready;

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    state_next    = state;
    sreg_next     = sreg;
    beat_next     = beat;
    load          = 1'b0;
    shift         = 1'b0;
    underrun_next = 1'b0;
    d1_next       = IDLE_LEVEL;
    d2_next       = IDLE_LEVEL;
    rst_next      = 1'b1;
    ce_next       = 1'b0;
    ready_next    = 1'b0;
    busy_next     = 1'b0;

    if (!lock_stable) begin
      state_next = HOLD;
    end else begin
      unique case (state)
        HOLD: state_next = IDLE;
        IDLE: begin
          if (accept) begin
            state_next = SHIFT;
            load       = 1'b1;
          end
        end
        SHIFT: begin
          if (beat != LAST_BEAT) begin
            shift = 1'b1;
          end else if (accept) begin
            load = 1'b1;
          end else begin
            state_next    = IDLE;
            underrun_next = 1'b1;
          end
        end
        default: state_next = HOLD;
      endcase
    end

    // Outputs are registered, so they are decoded from the state being entered.
    unique case (state_next)
      IDLE: begin
        rst_next   = 1'b0;
        ce_next    = 1'b1;
        ready_next = 1'b1;
        d1_next    = IDLE_D1;
        d2_next    = IDLE_D2;
      end
      SHIFT: begin
        rst_next  = 1'b0;
        ce_next   = 1'b1;
        busy_next = 1'b1;
        if (load) begin
          d1_next   = s_data[0];
          d2_next   = s_data[1];
          sreg_next = s_data >> 2;
          beat_next = '0;
        end else if (shift) begin
          d1_next   = sreg[0];
          d2_next   = sreg[1];
          sreg_next = sreg >> 2;
          beat_next = beat + 1'b1;
        end
        ready_next = (beat_next == LAST_BEAT);
      end
      default: begin
        beat_next = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= HOLD;
      sreg     <= '0;
      beat     <= '0;
      oddr_d1  <= IDLE_LEVEL;
      oddr_d2  <= IDLE_LEVEL;
      oddr_rst <= 1'b1;
      oddr_ce  <= 1'b0;
      s_ready  <= 1'b0;
      busy     <= 1'b0;
      underrun <= 1'b0;
    end else begin
      state    <= state_next;
      sreg     <= sreg_next;
      beat     <= beat_next;
      oddr_d1  <= d1_next;
      oddr_d2  <= d2_next;
      oddr_rst <= rst_next;
      oddr_ce  <= ce_next;
      s_ready  <= ready_next;
      busy     <= busy_next;
      underrun <= underrun_next;
    end
  end

endmodule

// File: tb/tb_oddr_word_sequencer.sv
// Directed bench for oddr_word_sequencer: reset/settle, single and back-to-back
// words, lock loss mid-word, lock glitch during settle, idle pattern, async reset.
module tb_oddr_word_sequencer;

  localparam int   WORD_W     = 8;
  localparam int   SETTLE     = 4;
  localparam logic IDLE_LEVEL = 1'b1;

`ifdef ODDR_SEQ_TRAINING_EN
  localparam logic EXP_IDLE_D1 = 1'b1;
  localparam logic EXP_IDLE_D2 = 1'b0;
`else
  localparam logic EXP_IDLE_D1 = IDLE_LEVEL;
  localparam logic EXP_IDLE_D2 = IDLE_LEVEL;
`endif

  logic              clk = 1'b0;
  logic              rst_n;
  logic              pll_locked;
  logic              s_valid;
  logic              s_ready;
  logic [WORD_W-1:0] s_data;
  logic              oddr_d1, oddr_d2, oddr_ce, oddr_rst, busy, underrun;

  oddr_word_sequencer #(
    .WORD_W       (WORD_W),
    .SETTLE_CYCLES(SETTLE),
    .IDLE_LEVEL   (IDLE_LEVEL)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .pll_locked(pll_locked),
    .s_valid   (s_valid),
    .s_ready   (s_ready),
    .s_data    (s_data),
    .oddr_d1   (oddr_d1),
    .oddr_d2   (oddr_d2),
    .oddr_ce   (oddr_ce),
    .oddr_rst  (oddr_rst),
    .busy      (busy),
    .underrun  (underrun)
  );

  always #5 clk = ~clk;

  // Observed vector: {d1, d2, rst, ce, s_ready, busy, underrun}
  logic [6:0] obs;
  assign obs = {oddr_d1, oddr_d2, oddr_rst, oddr_ce, s_ready, busy, underrun};

  int passed = 0;
  int total  = 0;

  function automatic logic [6:0] hold_v();
    return {IDLE_LEVEL, IDLE_LEVEL, 5'b10000};
  endfunction

  function automatic logic [6:0] idle_v(input logic und);
    return {EXP_IDLE_D1, EXP_IDLE_D2, 4'b0110, und};
  endfunction

  function automatic logic [6:0] shift_v(input logic d1, input logic d2, input logic rdy);
    return {d1, d2, 1'b0, 1'b1, rdy, 1'b1, 1'b0};
  endfunction

  task automatic check(input string tag, input logic [6:0] got, input logic [6:0] exp);
    total++;
    assert (got === exp) passed++;
    else $error("FAIL %s: observed %b expected %b (d1 d2 rst ce rdy busy und)", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  logic [1:0] b4_beats [4];

  initial begin
    // (d1,d2) per beat of 8'hB4 = 1011_0100, LSB pair first
    b4_beats = '{2'b00, 2'b10, 2'b11, 2'b01};
    rst_n      = 1'b0;
    pll_locked = 1'b1;
    s_valid    = 1'b0;
    s_data     = '0;

    // Reset values and settle from rst_n release with lock already high
    @(negedge clk);
    check("reset", obs, hold_v());
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < SETTLE + 2; k++) begin
      step();
      check($sformatf("settle_hold_%0d", k), obs, hold_v());
    end
    step();
    check("settle_ready", obs, idle_v(1'b0));

    // Single word then underrun
    s_valid = 1'b1;
    s_data  = 8'hB4;
    step();
    s_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      check($sformatf("b4_beat%0d", k), obs, shift_v(b4_beats[k][1], b4_beats[k][0], k == 3));
      step();
    end
    check("b4_underrun", obs, idle_v(1'b1));
    step();
    check("b4_idle", obs, idle_v(1'b0));

    // Back-to-back FF then 00 with s_valid held
    s_valid = 1'b1;
    s_data  = 8'hFF;
    step();
    s_data = 8'h00;
    for (int i = 0; i < 8; i++) begin
      check($sformatf("b2b_beat%0d", i), obs,
            shift_v(i < 4, i < 4, (i % 4) == 3));
      if (i == 4) s_valid = 1'b0;
      if (i < 7) step();
    end
    step();
    check("b2b_underrun", obs, idle_v(1'b1));
    step();
    check("b2b_idle", obs, idle_v(1'b0));

    // Lock loss during beat 1
    s_valid = 1'b1;
    s_data  = 8'hB4;
    step();
    s_valid = 1'b0;
    check("loss_beat0", obs, shift_v(1'b0, 1'b0, 1'b0));
    step();
    check("loss_beat1", obs, shift_v(1'b1, 1'b0, 1'b0));
    pll_locked = 1'b0;
    step();
    check("loss_edge0", obs, shift_v(1'b1, 1'b1, 1'b0));
    step();
    check("loss_edge1", obs, shift_v(1'b0, 1'b1, 1'b1));
    step();
    check("loss_hold", obs, hold_v());
    step();
    check("loss_hold_stays", obs, hold_v());
    pll_locked = 1'b1;
    for (int k = 0; k < SETTLE + 2; k++) begin
      step();
      check($sformatf("relock_hold_%0d", k), obs, hold_v());
    end
    step();
    check("relock_idle", obs, idle_v(1'b0));
    step();
    check("relock_not_resumed", obs, idle_v(1'b0));

    // One-cycle lock glitch during the settle count restarts it
    pll_locked = 1'b0;
    step();
    step();
    step();
    check("glitch_pre_hold", obs, hold_v());
    pll_locked = 1'b1;
    for (int k = 0; k < 10; k++) begin
      step();
      check($sformatf("glitch_hold_%0d", k), obs, hold_v());
      if (k == 2) pll_locked = 1'b0;
      if (k == 3) pll_locked = 1'b1;
    end
    step();
    check("glitch_idle", obs, idle_v(1'b0));

    // Idle data pattern over several cycles
    for (int k = 0; k < 4; k++) begin
      step();
      check($sformatf("idle_pattern_%0d", k), obs, idle_v(1'b0));
    end

    // Asynchronous reset mid-word, sampled between clock edges
    s_valid = 1'b1;
    s_data  = 8'hB4;
    step();
    s_valid = 1'b0;
    step();
    check("arst_pre_beat1", obs, shift_v(1'b1, 1'b0, 1'b0));
    #2 rst_n = 1'b0;
    #1;
    check("arst_immediate", obs, hold_v());

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
